cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_seq_pkg.sv | 6 +
 rtl/rom_loader.sv | 31 +++
 rtl/cpu_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding and image sizes for the CPU run sequencer
package cpu_seq_pkg;
   localparam int ROM_BYTES     = 128;
   localparam int MEM_OUT_BYTES = 24;
   typedef enum logic [1:0] {IDLE, RUN, CAPTURE, DONE} state_t;
endpackage

// File: rtl/rom_loader.sv
// rom_loader: 128-byte program image filled through a valid/ready byte port
// Ports: clk, rst (sync, active-high); en opens the write port (IDLE only);
// clr rewinds the write pointer; load_valid/load_data/load_ready byte port;
// rom is the packed image, byte k at rom[8k+:8].
module rom_loader import cpu_seq_pkg::*; (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clr,
   input  logic                     load_valid,
   input  logic [7:0]               load_data,
   output logic                     load_ready,
   output logic [ROM_BYTES*8-1:0]   rom
);
   localparam int AW = $clog2(ROM_BYTES);
   logic [AW-1:0] wptr;
   assign load_ready = en;
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rom  <= '0;
      end else begin
         if (en && load_valid) begin
            rom[{wptr, 3'b000} +: 8] <= load_data;
            wptr                     <= wptr + AW'(1);
         end
         // a start on the same edge as a write stores the byte, then rewinds
         if (clr) wptr <= '0;
      end
   end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: loads a CPU program, runs it to halt flag or cycle budget, captures memory
// Ports: clk, rst (sync, active-high); load_valid/load_data/load_ready ROM byte port;
// start/max_cycles run request; rom image and cpu_rst to the CPU; mem_in from the CPU;
// result/result_valid/result_ready capture handshake; cycles_used, halted, timeout, busy status.
module cpu_sequencer import cpu_seq_pkg::*; #(
   parameter int HALT_IDX = 23,
   parameter int CYC_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_valid,
   input  logic [7:0]                  load_data,
   output logic                        load_ready,
   input  logic                        start,
   input  logic [CYC_W-1:0]            max_cycles,
   output logic [ROM_BYTES*8-1:0]      rom,
   output logic                        cpu_rst,
   input  logic [MEM_OUT_BYTES*8-1:0]  mem_in,
   output logic [MEM_OUT_BYTES*8-1:0]  result,
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic [CYC_W-1:0]            cycles_used,
   output logic                        halted,
   output logic                        timeout,
   output logic                        busy
);
   state_t           state, state_nx;
   logic [CYC_W-1:0] max_q;
   logic             go, halt_hit, budget_hit;
   assign go         = (state == IDLE) && start;
   assign halt_hit   = mem_in[HALT_IDX*8 +: 8] != 8'd0;
   assign budget_hit = cycles_used == max_q - CYC_W'(1);
   rom_loader u_rom (
      .clk        (clk),
      .rst        (rst),
      .en         (state == IDLE),
      .clr        (go),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .rom        (rom)
   );
   always_comb begin
      state_nx     = state;
      cpu_rst      = state != RUN;
      result_valid = state == DONE;
      busy         = state != IDLE;
      case (state)
         IDLE:    state_nx = start ? (max_cycles != '0 ? RUN : CAPTURE) : IDLE;
         RUN:     state_nx = (halt_hit || budget_hit) ? CAPTURE : RUN;
         CAPTURE: state_nx = DONE;
         DONE:    state_nx = result_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         max_q       <= '0;
         cycles_used <= '0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
         result      <= '0;
      end else begin
         state <= state_nx;
         if (go) begin
            max_q       <= max_cycles;
            cycles_used <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
         end
         if (state == RUN) begin
            cycles_used <= &cycles_used ? cycles_used : cycles_used + CYC_W'(1);
            // halt wins when both end conditions land on the same edge
            halted      <= halt_hit;
            timeout     <= !halt_hit && budget_hit;
         end
         // CPU memory still shows its post-final state during CAPTURE
         if (state == CAPTURE) result <= mem_in;
      end
   end
endmodule
